// File: rtl/grf_wb_arbiter.sv
// Register-file write-port arbiter between W-stage writeback and late MDU results.
// Tracks outstanding MDU destinations and raises a D-stage stall on hazards against them.
module grf_wb_arbiter #(
  parameter int MAX_PENDING  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        W_we,
  input  logic [4:0]  W_a3,
  input  logic [31:0] W_wd,
  input  logic [31:0] W_pc,
  input  logic [4:0]  D_A1,
  input  logic [4:0]  D_A2,
  input  logic        D_wen,
  input  logic [4:0]  D_wa,
  input  logic        mdu_issue,
  input  logic [4:0]  mdu_dst,
  output logic        mdu_issue_ready,
  input  logic        mdu_wb_valid,
  input  logic [4:0]  mdu_wb_a3,
  input  logic [31:0] mdu_wb_wd,
  input  logic [31:0] mdu_wb_pc,
  output logic        mdu_wb_ready,
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_wpc,
  output logic        stall
);

  // state | meaning
  // IDLE  | no MDU result parked; MDU results accepted and forwarded when W is idle
  // HOLD  | one MDU result parked in the hold registers, waiting for an idle W cycle
  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state, state_nx;
  logic [31:0] pending, pending_nx;
  logic [2:0]  cnt, cnt_nx;
  logic [7:0]  age, age_nx;
  logic [4:0]  hold_a3;
  logic [31:0] hold_wd, hold_pc;

  logic        pipe_wr, hold_load, commit, commit_dec, issue_acc, cnt_ok, starve, hazard;
  logic        sel_v, mrdy_c;
  logic [4:0]  sel_a3, commit_a3;
  logic [31:0] sel_wd, sel_pc;

  assign pipe_wr = W_we && (W_a3 != 5'd0);
  assign cnt_ok  = cnt < 3'(MAX_PENDING);

  always_comb begin
    state_nx  = state;
    age_nx    = age;
    hold_load = 1'b0;
    commit    = 1'b0;
    commit_a3 = mdu_wb_a3;
    mrdy_c    = 1'b0;
    sel_v     = 1'b0;
    sel_a3    = W_a3;
    sel_wd    = W_wd;
    sel_pc    = W_pc;
    case (state)
      IDLE: begin
        mrdy_c = 1'b1;
        age_nx = 8'd0;
        if (pipe_wr) begin
          sel_v = 1'b1;
          if (mdu_wb_valid) begin
            hold_load = 1'b1;
            state_nx  = HOLD;
          end
        end else if (mdu_wb_valid) begin
          sel_v     = 1'b1;
          sel_a3    = mdu_wb_a3;
          sel_wd    = mdu_wb_wd;
          sel_pc    = mdu_wb_pc;
          commit    = 1'b1;
          commit_a3 = mdu_wb_a3;
        end
      end
      HOLD: begin
        if (pipe_wr) begin
          sel_v  = 1'b1;
          age_nx = (age == 8'hFF) ? age : age + 8'd1;
        end else begin
          sel_v     = 1'b1;
          sel_a3    = hold_a3;
          sel_wd    = hold_wd;
          sel_pc    = hold_pc;
          commit    = 1'b1;
          commit_a3 = hold_a3;
          state_nx  = IDLE;
          age_nx    = 8'd0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Starvation guard: the stall bubbles W so the parked result can drain.
  assign starve = (state == HOLD) && (age >= 8'(STARVE_LIMIT));
  assign hazard = ((D_A1 != 5'd0) && pending[D_A1]) ||
                  ((D_A2 != 5'd0) && pending[D_A2]) ||
                  (D_wen && (D_wa != 5'd0) && pending[D_wa]);

  assign stall           = !reset && (hazard || (mdu_issue && !cnt_ok) || starve);
  assign mdu_issue_ready = reset || cnt_ok;
  assign mdu_wb_ready    = !reset && mrdy_c;
  assign grf_we          = !reset && sel_v && (sel_a3 != 5'd0);
  assign grf_a3          = sel_a3;
  assign grf_wd          = sel_wd;
  assign grf_wpc         = sel_pc;

  assign issue_acc  = mdu_issue && cnt_ok && !stall;
  assign commit_dec = commit && (cnt != 3'd0);
  assign cnt_nx     = cnt + {2'b00, issue_acc} - {2'b00, commit_dec};

  // Clear before set so a same-cycle reissue to the same register stays pending.
  always_comb begin
    pending_nx = pending;
    if (commit && (commit_a3 != 5'd0)) pending_nx[commit_a3] = 1'b0;
    if (issue_acc && (mdu_dst != 5'd0)) pending_nx[mdu_dst] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pending <= '0;
      cnt     <= '0;
      age     <= '0;
      hold_a3 <= '0;
      hold_wd <= '0;
      hold_pc <= '0;
    end else begin
      state   <= state_nx;
      pending <= pending_nx;
      cnt     <= cnt_nx;
      age     <= age_nx;
      if (hold_load) begin
        hold_a3 <= mdu_wb_a3;
        hold_wd <= mdu_wb_wd;
        hold_pc <= mdu_wb_pc;
      end
    end
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Bench for grf_wb_arbiter: directed per-cycle vector table, starvation sequence,
// then random traffic compared against a queue-level reference model.
module tb_grf_wb_arbiter;
  localparam int MAXP  = 2;
  localparam int LIMIT = 4;

  logic clk, reset;
  logic W_we, D_wen, mdu_issue, mdu_wb_valid;
  logic [4:0] W_a3, D_A1, D_A2, D_wa, mdu_dst, mdu_wb_a3;
  logic [31:0] W_wd, W_pc, mdu_wb_wd, mdu_wb_pc;
  logic mdu_issue_ready, mdu_wb_ready, grf_we, stall;
  logic [4:0] grf_a3;
  logic [31:0] grf_wd, grf_wpc;

  int errors = 0;
  int checks = 0;

  grf_wb_arbiter #(.MAX_PENDING(MAXP), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .W_we(W_we), .W_a3(W_a3), .W_wd(W_wd), .W_pc(W_pc),
    .D_A1(D_A1), .D_A2(D_A2), .D_wen(D_wen), .D_wa(D_wa),
    .mdu_issue(mdu_issue), .mdu_dst(mdu_dst), .mdu_issue_ready(mdu_issue_ready),
    .mdu_wb_valid(mdu_wb_valid), .mdu_wb_a3(mdu_wb_a3), .mdu_wb_wd(mdu_wb_wd),
    .mdu_wb_pc(mdu_wb_pc), .mdu_wb_ready(mdu_wb_ready),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_wpc(grf_wpc),
    .stall(stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic rst; logic wwe; logic [4:0] wa3; logic [31:0] wwd;
    logic mv; logic [4:0] ma3; logic [31:0] mwd;
    logic iss; logic [4:0] dst; logic [4:0] a1; logic [4:0] a2; logic dwen; logic [4:0] dwa;
    logic e_we; logic [4:0] e_a3; logic [31:0] e_wd; logic e_mrdy; logic e_stall; logic e_irdy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rst, input logic wwe, input logic [4:0] wa3,
      input logic [31:0] wwd, input logic mv, input logic [4:0] ma3, input logic [31:0] mwd,
      input logic iss, input logic [4:0] dst, input logic [4:0] a1, input logic [4:0] a2,
      input logic dwen, input logic [4:0] dwa, input logic e_we, input logic [4:0] e_a3,
      input logic [31:0] e_wd, input logic e_mrdy, input logic e_stall, input logic e_irdy);
    vec_t x;
    x.rst = rst; x.wwe = wwe; x.wa3 = wa3; x.wwd = wwd; x.mv = mv; x.ma3 = ma3; x.mwd = mwd;
    x.iss = iss; x.dst = dst; x.a1 = a1; x.a2 = a2; x.dwen = dwen; x.dwa = dwa;
    x.e_we = e_we; x.e_a3 = e_a3; x.e_wd = e_wd; x.e_mrdy = e_mrdy; x.e_stall = e_stall; x.e_irdy = e_irdy;
    return x;
  endfunction

  task automatic drive(input vec_t x);
    reset = x.rst; W_we = x.wwe; W_a3 = x.wa3; W_wd = x.wwd; W_pc = x.wwd + 32'h100;
    mdu_wb_valid = x.mv; mdu_wb_a3 = x.ma3; mdu_wb_wd = x.mwd; mdu_wb_pc = x.mwd + 32'h200;
    mdu_issue = x.iss; mdu_dst = x.dst; D_A1 = x.a1; D_A2 = x.a2; D_wen = x.dwen; D_wa = x.dwa;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model state: scoreboard as a bit array, count as an int, parked result as a queue.
  typedef struct { logic [4:0] a3; logic [31:0] wd; logic [31:0] pc; } res_t;
  bit   m_pend[32];
  int   m_cnt;
  res_t m_held[$];
  int   m_age;

  initial begin
    vec_t idle;
    idle = v(0, 0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0, 1,0,1);
    drive(idle);

    //        rst wwe a3 wd        mv a3 wd        iss dst a1 a2 dwen dwa  e_we a3 wd        mrdy stall irdy
    tbl.push_back(v(1, 1,5,32'h1234,  1,8,32'hB,     1,3,  0,0, 0,0,   0,0,0,           0,0,1));
    tbl.push_back(v(0, 1,5,32'h1234,  0,0,0,         0,0,  0,0, 0,0,   1,5,32'h1234,    1,0,1));
    tbl.push_back(v(0, 1,3,32'hA,     1,8,32'hB,     0,0,  0,0, 0,0,   1,3,32'hA,       1,0,1));
    tbl.push_back(v(0, 0,0,0,         0,0,0,         0,0,  0,0, 0,0,   1,8,32'hB,       0,0,1));
    tbl.push_back(v(0, 0,0,0,         0,0,0,         0,0,  0,0, 0,0,   0,0,0,           1,0,1));
    tbl.push_back(v(0, 0,0,0,         0,0,0,         1,9,  0,0, 0,0,   0,0,0,           1,0,1));
    tbl.push_back(v(0, 0,0,0,         0,0,0,         0,0,  9,0, 0,0,   0,0,0,           1,1,1));
    tbl.push_back(v(0, 0,0,0,         1,9,32'h99,    0,0,  9,0, 0,0,   1,9,32'h99,      1,1,1));
    tbl.push_back(v(0, 0,0,0,         0,0,0,         0,0,  9,0, 0,0,   0,0,0,           1,0,1));
    tbl.push_back(v(0, 0,0,0,         0,0,0,         1,4,  0,0, 0,0,   0,0,0,           1,0,1));
    tbl.push_back(v(0, 0,0,0,         0,0,0,         1,6,  0,0, 0,0,   0,0,0,           1,0,1));
    tbl.push_back(v(0, 0,0,0,         0,0,0,         1,2,  0,0, 0,0,   0,0,0,           1,1,0));
    tbl.push_back(v(0, 0,0,0,         1,4,32'h44,    0,0,  0,0, 0,0,   1,4,32'h44,      1,0,0));
    tbl.push_back(v(0, 0,0,0,         0,0,0,         0,0,  0,0, 0,0,   0,0,0,           1,0,1));
    tbl.push_back(v(0, 0,0,0,         0,0,0,         0,0,  0,0, 1,6,   0,0,0,           1,1,1));
    tbl.push_back(v(0, 0,0,0,         0,0,0,         0,0,  0,0, 0,6,   0,0,0,           1,0,1));
    tbl.push_back(v(0, 1,0,32'h77,    1,6,32'h66,    0,0,  0,0, 0,0,   1,6,32'h66,      1,0,1));
    tbl.push_back(v(0, 0,0,0,         1,0,32'h5,     0,0,  0,0, 0,0,   0,0,0,           1,0,1));
    tbl.push_back(v(0, 0,0,0,         0,0,0,         1,7,  0,0, 0,0,   0,0,0,           1,0,1));
    tbl.push_back(v(0, 1,1,32'h11,    1,7,32'h77,    0,0,  0,0, 0,0,   1,1,32'h11,      1,0,1));
    tbl.push_back(v(1, 0,0,0,         0,0,0,         0,0,  7,0, 0,0,   0,0,0,           0,0,1));
    tbl.push_back(v(0, 0,0,0,         0,0,0,         0,0,  7,0, 0,0,   0,0,0,           1,0,1));
    tbl.push_back(v(0, 0,0,0,         0,0,0,         1,0,  0,0, 0,0,   0,0,0,           1,0,1));
    tbl.push_back(v(0, 0,0,0,         1,0,32'h9,     0,0,  0,0, 0,0,   0,0,0,           1,0,1));
    tbl.push_back(v(0, 0,0,0,         0,0,0,         1,5,  0,0, 0,0,   0,0,0,           1,0,1));
    tbl.push_back(v(0, 0,0,0,         0,0,0,         1,3,  0,0, 0,0,   0,0,0,           1,0,1));
    tbl.push_back(v(0, 0,0,0,         0,0,0,         0,0,  0,0, 0,0,   0,0,0,           1,0,0));
    tbl.push_back(v(1, 0,0,0,         0,0,0,         0,0,  0,0, 0,0,   0,0,0,           0,0,1));
    tbl.push_back(v(0, 0,0,0,         0,0,0,         1,5,  0,0, 0,0,   0,0,0,           1,0,1));
    tbl.push_back(v(0, 0,0,0,         1,5,32'h55,    1,5,  0,0, 0,0,   1,5,32'h55,      1,0,1));
    tbl.push_back(v(0, 0,0,0,         0,0,0,         0,0,  5,0, 0,0,   0,0,0,           1,1,1));
    tbl.push_back(v(1, 0,0,0,         0,0,0,         0,0,  0,0, 0,0,   0,0,0,           0,0,1));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d grf_we", i), 32'(grf_we), 32'(tbl[i].e_we));
      chk($sformatf("v%0d mdu_wb_ready", i), 32'(mdu_wb_ready), 32'(tbl[i].e_mrdy));
      chk($sformatf("v%0d stall", i), 32'(stall), 32'(tbl[i].e_stall));
      chk($sformatf("v%0d issue_ready", i), 32'(mdu_issue_ready), 32'(tbl[i].e_irdy));
      if (tbl[i].e_we) begin
        chk($sformatf("v%0d grf_a3", i), 32'(grf_a3), 32'(tbl[i].e_a3));
        chk($sformatf("v%0d grf_wd", i), grf_wd, tbl[i].e_wd);
      end
    end

    // Starvation: park r2, keep W busy, stall once the result has waited LIMIT cycles.
    @(negedge clk);
    drive(v(0, 1,1,32'h1, 1,2,32'h22, 0,0, 0,0,0,0, 0,0,0, 0,0,0));
    #1 chk("starve collide a3", 32'(grf_a3), 32'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(v(0, 1,1,32'h1, 0,0,0, 0,0, 0,0,0,0, 0,0,0, 0,0,0));
      #1 chk($sformatf("starve stall c%0d", i), 32'(stall), (i >= LIMIT) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    drive(idle);
    #1;
    chk("starve drain we", 32'(grf_we), 32'd1);
    chk("starve drain a3", 32'(grf_a3), 32'd2);
    chk("starve drain wd", grf_wd, 32'h22);
    chk("starve drain wpc", grf_wpc, 32'h222);
    chk("starve drain stall", 32'(stall), 32'd1);
    @(negedge clk);
    #1;
    chk("starve after stall", 32'(stall), 32'd0);
    chk("starve after mrdy", 32'(mdu_wb_ready), 32'd1);

    // Random traffic against the reference model, starting from reset.
    @(negedge clk);
    drive(v(1, 0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0, 0,0,0));
    foreach (m_pend[i]) m_pend[i] = 0;
    m_cnt = 0; m_held.delete(); m_age = 0;
    for (int n = 0; n < 3000; n++) begin
      logic pw, e_we, e_stall, e_irdy, e_mrdy, commit;
      logic [4:0] e_a3, ca3;
      logic [31:0] e_wd, e_pc;
      res_t r;
      @(negedge clk);
      reset        = ($urandom_range(0, 99) == 0);
      W_we         = $urandom_range(0, 1) == 1;
      W_a3         = 5'($urandom_range(0, 7));
      W_wd         = $urandom;
      W_pc         = $urandom;
      mdu_wb_valid = $urandom_range(0, 2) == 0;
      mdu_wb_a3    = 5'($urandom_range(0, 7));
      mdu_wb_wd    = $urandom;
      mdu_wb_pc    = $urandom;
      mdu_issue    = $urandom_range(0, 3) == 0;
      mdu_dst      = 5'($urandom_range(0, 7));
      D_A1         = 5'($urandom_range(0, 7));
      D_A2         = 5'($urandom_range(0, 7));
      D_wen        = $urandom_range(0, 1) == 1;
      D_wa         = 5'($urandom_range(0, 7));
      #1;
      pw     = W_we && (W_a3 != 0);
      e_irdy = m_cnt < MAXP;
      e_mrdy = (m_held.size() == 0);
      e_stall = (D_A1 != 0 && m_pend[D_A1]) || (D_A2 != 0 && m_pend[D_A2]) ||
                (D_wen && D_wa != 0 && m_pend[D_wa]) || (mdu_issue && !e_irdy) ||
                (m_held.size() != 0 && m_age >= LIMIT);
      e_we = 0; e_a3 = 0; e_wd = 0; e_pc = 0;
      if (pw) begin
        e_we = 1; e_a3 = W_a3; e_wd = W_wd; e_pc = W_pc;
      end else if (m_held.size() != 0) begin
        e_we = (m_held[0].a3 != 0); e_a3 = m_held[0].a3; e_wd = m_held[0].wd; e_pc = m_held[0].pc;
      end else if (mdu_wb_valid) begin
        e_we = (mdu_wb_a3 != 0); e_a3 = mdu_wb_a3; e_wd = mdu_wb_wd; e_pc = mdu_wb_pc;
      end
      if (reset) begin
        e_we = 0; e_mrdy = 0; e_stall = 0; e_irdy = 1;
      end
      chk($sformatf("rnd%0d grf_we", n), 32'(grf_we), 32'(e_we));
      chk($sformatf("rnd%0d mdu_wb_ready", n), 32'(mdu_wb_ready), 32'(e_mrdy));
      chk($sformatf("rnd%0d stall", n), 32'(stall), 32'(e_stall));
      chk($sformatf("rnd%0d issue_ready", n), 32'(mdu_issue_ready), 32'(e_irdy));
      if (e_we) begin
        chk($sformatf("rnd%0d grf_a3", n), 32'(grf_a3), 32'(e_a3));
        chk($sformatf("rnd%0d grf_wd", n), grf_wd, e_wd);
        chk($sformatf("rnd%0d grf_wpc", n), grf_wpc, e_pc);
      end
      if (reset) begin
        foreach (m_pend[i]) m_pend[i] = 0;
        m_cnt = 0; m_held.delete(); m_age = 0;
      end else begin
        commit = 0; ca3 = 0;
        if (m_held.size() != 0) begin
          if (pw) m_age++;
          else begin
            commit = 1; ca3 = m_held[0].a3; m_held.delete(); m_age = 0;
          end
        end else if (mdu_wb_valid) begin
          if (pw) begin
            r.a3 = mdu_wb_a3; r.wd = mdu_wb_wd; r.pc = mdu_wb_pc;
            m_held.push_back(r); m_age = 0;
          end else begin
            commit = 1; ca3 = mdu_wb_a3;
          end
        end
        if (commit) begin
          if (ca3 != 0) m_pend[ca3] = 0;
          if (m_cnt > 0) m_cnt--;
        end
        if (mdu_issue && e_irdy && !e_stall) begin
          m_cnt++;
          if (mdu_dst != 0) m_pend[mdu_dst] = 1;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Arbitrates the single register-file write port between the main pipeline writeback (W stage) and the multi-cycle multiply/divide unit (MDU), which returns results late.
- Keeps a scoreboard of registers with an MDU write outstanding and raises a D-stage stall on RAW/WAW hazards against them.
- Sits between the W-stage registers, the MDU and the register-file write port, in the same clock domain as the register file.

Parameters:
- MAX_PENDING, 2: maximum number of MDU writes outstanding (issued but not yet written), range 1..4.
- STARVE_LIMIT, 4: cycles an MDU result may wait in HOLD before stall is forced.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; clears all state.
- W_we  in  1  pipeline writeback enable.
- W_a3  in  5  pipeline writeback register.
- W_wd  in  32  pipeline writeback data.
- W_pc  in  32  pipeline writeback PC.
- D_A1  in  5  D-stage source register 1.
- D_A2  in  5  D-stage source register 2.
- D_wen  in  1  D-stage instruction will write a register.
- D_wa  in  5  D-stage destination register.
- mdu_issue  in  1  D-stage MDU op issuing this cycle (only honoured when mdu_issue_ready=1 and stall=0).
- mdu_dst  in  5  destination of the issuing MDU op.
- mdu_issue_ready  out  1  outstanding count < MAX_PENDING.
- mdu_wb_valid  in  1  MDU result available.
- mdu_wb_a3  in  5  MDU result register.
- mdu_wb_wd  in  32  MDU result data.
- mdu_wb_pc  in  32  PC of the MDU op.
- mdu_wb_ready  out  1  arbiter accepts the MDU result this cycle.
- grf_we  out  1  register-file write enable.
- grf_a3  out  5  register-file write address.
- grf_wd  out  32  register-file write data.
- grf_wpc  out  32  PC of the write, for trace output.
- stall  out  1  freeze F/D and bubble E.

Behaviour:
- Reset:
  - pending[31:0]=0, outstanding count=0, state=IDLE, age=0, hold registers=0.
  - While reset is high: grf_we=0, mdu_wb_ready=0, stall=0, mdu_issue_ready=1.
  - Reset mid-operation discards a held result and all pending bits.
- State machine:
  - IDLE:
    - mdu_wb_ready=1.
    - Pipeline write present (W_we=1, W_a3!=0): it drives the grf port. A simultaneous MDU handshake latches the result into the hold registers; next state HOLD.
    - No pipeline write: the MDU result (if valid) passes combinationally to the grf port the same cycle; stay IDLE.
  - HOLD:
    - mdu_wb_ready=0.
    - Pipeline write present: pipeline wins, age+1.
    - Otherwise: the held result drives the grf port; next state IDLE, age=0.
- $0 handling:
  - The grf port never writes $0; grf_we=0 whenever the selected address is 0.
  - A W_we with W_a3=0 counts as "no pipeline write".
  - An MDU result to $0 is accepted and dropped.
- Scoreboard:
  - mdu_issue accepted with mdu_dst!=0: sets pending[mdu_dst] and count+1.
  - MDU result committed to the grf port: clears pending[a3] and count-1.
  - Issue with mdu_dst=0: count+1 only; the matching $0 result does count-1.
  - Set and clear of the same register in the same cycle: the register ends set (new op).
  - Count never exceeds MAX_PENDING and never underflows; a commit with count=0 is ignored.
- Stall (combinational) is 1 if any of:
  - D_A1!=0 and pending[D_A1].
  - D_A2!=0 and pending[D_A2].
  - D_wen and D_wa!=0 and pending[D_wa] (WAW).
  - mdu_issue and !mdu_issue_ready.
  - state=HOLD and age>=STARVE_LIMIT (starvation guard: stall forces a bubble into W so the held result drains).
- Hazard window: pending is cleared by the commit edge, so a reader stalled on register r proceeds in the cycle after r is written.
- Latency: MDU result reaches the grf port 0 cycles after the handshake if unopposed, otherwise ≥1 cycle.

Test Plan:
- Pipeline only: W_we=1, W_a3=5, W_wd=0x1234 -> grf_we=1, grf_a3=5, grf_wd=0x1234 same cycle; state stays IDLE.
- Collision: W writes r3=0xA while MDU delivers r8=0xB -> cycle n: grf r3=0xA, mdu_wb_ready=1, state HOLD. Cycle n+1 with W idle: grf r8=0xB, state IDLE.
- RAW stall: issue MDU to r9; D_A1=9 held -> stall=1 until the r9 commit, 0 the cycle after. D_A2=0 never stalls.
- Capacity: MAX_PENDING=2, two issues to r4,r6, third issue -> mdu_issue_ready=0, stall=1; after the r4 commit -> ready=1.
- Starvation: HOLD with W_we=1 every cycle -> stall=1 once age=4; first idle W cycle drains the hold; stall drops.
- Reset mid-HOLD with pending r7 -> next cycle pending=0, IDLE, D_A1=7 gives stall=0, grf_we=0; MDU write to $0 -> grf_we=0, count decremented.
